// File: rtl/lector_colas_rr_pkg.sv
// Constants shared between the round-robin scheduler and the queue reader.
package lector_colas_rr_pkg;
  localparam int QUEUE_QUANTITY = 4;
  localparam int DATA_BITS      = 8;
  localparam int SEL_BITS       = $clog2(QUEUE_QUANTITY);
  localparam int CNT_BITS       = 16;
  localparam logic [CNT_BITS-1:0] CNT_SAT = '1;
endpackage

// File: rtl/lector_colas_rr_contador_saturado.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module contador_saturado #(
  parameter int CNT_BITS = lector_colas_rr_pkg::CNT_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  output logic [CNT_BITS-1:0] count
);
  localparam logic [CNT_BITS-1:0] SAT = '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     count <= '0;
    else if (inc && count != SAT) count <= count + 1'b1;
  end
endmodule

// File: rtl/lector_colas_rr.sv
// Pops the FIFO chosen by the scheduler and forwards the word tagged with its
// source queue two cycles later; keeps per-queue service and underrun counts.
module lector_colas_rr #(
  parameter  int QUEUE_QUANTITY = lector_colas_rr_pkg::QUEUE_QUANTITY,
  parameter  int DATA_BITS      = lector_colas_rr_pkg::DATA_BITS,
  parameter  int CNT_BITS       = lector_colas_rr_pkg::CNT_BITS,
  localparam int SEL_BITS       = $clog2(QUEUE_QUANTITY)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enb,
  input  logic [SEL_BITS-1:0]                 selector,
  input  logic                                selector_enb,
  input  logic [QUEUE_QUANTITY-1:0]           fifo_empty,
  input  logic [QUEUE_QUANTITY*DATA_BITS-1:0] fifo_data,
  output logic [QUEUE_QUANTITY-1:0]           fifo_pop,
  output logic [QUEUE_QUANTITY-1:0]           buf_empty,
  output logic [DATA_BITS-1:0]                data_out,
  output logic [SEL_BITS-1:0]                 data_queue,
  output logic                                data_valid,
  output logic                                underrun,
  input  logic [SEL_BITS-1:0]                 count_sel,
  output logic [CNT_BITS-1:0]                 count_out,
  output logic [CNT_BITS-1:0]                 underrun_count
);
  logic                 req, sel_ok, hit, miss;
  logic                 s1_valid;
  logic [SEL_BITS-1:0]  s1_tag;
  logic [QUEUE_QUANTITY-1:0][CNT_BITS-1:0] svc_cnt;

  assign buf_empty = fifo_empty;

  // Reset also gates the pop so nothing leaves a FIFO while the pipe is cleared.
  assign req    = enb & selector_enb & ~rst;
  assign sel_ok = int'(selector) < QUEUE_QUANTITY;
  assign hit    = req && sel_ok && !fifo_empty[selector];
  assign miss   = req && !hit;

  always_comb begin
    fifo_pop = '0;
    if (hit) fifo_pop[selector] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_tag   <= '0;
      underrun <= 1'b0;
    end else begin
      s1_valid <= hit;
      s1_tag   <= selector;
      underrun <= miss;
    end
  end

  // FIFO read data is valid the cycle after the pop; output holds between words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      data_queue <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= s1_valid;
      if (s1_valid) begin
        data_out   <= fifo_data[s1_tag*DATA_BITS +: DATA_BITS];
        data_queue <= s1_tag;
      end
    end
  end

  for (genvar g = 0; g < QUEUE_QUANTITY; g++) begin : g_svc
    contador_saturado #(.CNT_BITS(CNT_BITS)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (data_valid && (data_queue == SEL_BITS'(g))),
      .count (svc_cnt[g])
    );
  end

  contador_saturado #(.CNT_BITS(CNT_BITS)) u_under (
    .clk   (clk),
    .rst   (rst),
    .inc   (underrun),
    .count (underrun_count)
  );

  assign count_out = (int'(count_sel) < QUEUE_QUANTITY) ? svc_cnt[count_sel] : '0;
endmodule

// File: tb/tb_lector_colas_rr.sv
// Randomized bench for lector_colas_rr against a per-cycle event-history model.
module tb_lector_colas_rr;
  localparam int QQ   = 4;
  localparam int DB   = 8;
  localparam int CB   = 4;
  localparam int SB   = 2;
  localparam int NCYC = 1600;
  localparam int CMAX = (1 << CB) - 1;

  logic               clk = 1'b0;
  logic               rst, enb, selector_enb;
  logic [SB-1:0]      selector, count_sel;
  logic [QQ-1:0]      fifo_empty, fifo_pop, buf_empty;
  logic [QQ*DB-1:0]   fifo_data;
  logic [DB-1:0]      data_out;
  logic [SB-1:0]      data_queue;
  logic               data_valid, underrun;
  logic [CB-1:0]      count_out, underrun_count;

  lector_colas_rr #(.QUEUE_QUANTITY(QQ), .DATA_BITS(DB), .CNT_BITS(CB)) dut (
    .clk(clk), .rst(rst), .enb(enb), .selector(selector), .selector_enb(selector_enb),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_pop(fifo_pop),
    .buf_empty(buf_empty), .data_out(data_out), .data_queue(data_queue),
    .data_valid(data_valid), .underrun(underrun), .count_sel(count_sel),
    .count_out(count_out), .underrun_count(underrun_count)
  );

  always #5 clk = ~clk;

  // History of what each cycle asked for; expectations are read back from it.
  bit            hit_h  [NCYC];
  bit            miss_h [NCYC];
  bit            rst_h  [NCYC];
  logic [SB-1:0] q_h    [NCYC];
  logic [DB-1:0] dat_h  [NCYC][QQ];

  int n_cmp = 0, n_bad = 0;
  int svc [QQ];
  int ucnt;
  logic [DB-1:0] e_dout;
  logic [SB-1:0] e_dq;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp, input int cyc);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic stim(input int c);
    logic [DB-1:0] d [QQ];
    rst = 1'b0; enb = 1'b1; selector_enb = 1'b0; selector = '0; fifo_empty = '0;
    for (int i = 0; i < QQ; i++) d[i] = DB'($urandom);
    if (c < 3)                    rst = 1'b1;
    else if (c <= 6) begin        // clean stream over all queues
      selector_enb = 1'b1; selector = SB'(c - 3);
      for (int i = 0; i < QQ; i++) d[i] = 8'hA0 + DB'(i);
    end
    else if (c == 10) begin       // request to an empty queue
      fifo_empty = 4'b0100; selector_enb = 1'b1; selector = 2'd2;
    end
    else if (c == 13) begin selector_enb = 1'b1; selector = 2'd1; end
    else if (c >= 14 && c <= 17) begin   // disabled while a word is in flight
      enb = 1'b0; selector_enb = 1'b1; selector = SB'($urandom);
    end
    else if (c == 20) begin selector_enb = 1'b1; selector = 2'd3; end
    else if (c == 21)             rst = 1'b1;
    else if (c >= 30 && c < 55) begin    // saturate queue 0 service count
      selector_enb = 1'b1; selector = 2'd0;
    end
    else if (c >= 60 && c < 85) begin    // saturate underrun count
      fifo_empty = '1; selector_enb = 1'b1; selector = SB'($urandom);
    end
    else if (c >= 90) begin
      rst          = ($urandom_range(0, 99) == 0);
      enb          = ($urandom_range(0, 7) != 0);
      selector_enb = ($urandom_range(0, 3) != 0);
      selector     = SB'($urandom);
      for (int i = 0; i < QQ; i++) fifo_empty[i] = ($urandom_range(0, 3) == 0);
    end
    count_sel = SB'($urandom);
    for (int i = 0; i < QQ; i++) begin
      fifo_data[i*DB +: DB] = d[i];
      dat_h[c][i] = d[i];
    end
    rst_h[c]  = rst;
    q_h[c]    = selector;
    hit_h[c]  = !rst && enb && selector_enb && !fifo_empty[selector];
    miss_h[c] = !rst && enb && selector_enb &&  fifo_empty[selector];
  endtask

  initial begin
    bit ev, eu;
    logic [QQ-1:0] e_pop;
    rst = 1'b1; enb = 1'b0; selector_enb = 1'b0; selector = '0; count_sel = '0;
    fifo_empty = '0; fifo_data = '0;
    for (int q = 0; q < QQ; q++) svc[q] = 0;
    ucnt = 0; e_dout = '0; e_dq = '0;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk); #1;
      stim(c);
      @(negedge clk);
      if (rst_h[c]) begin
        for (int q = 0; q < QQ; q++) svc[q] = 0;
        ucnt = 0; e_dout = '0; e_dq = '0;
      end
      // A popped word shows up two cycles later unless reset hits its pipeline.
      ev = (c >= 2) && hit_h[c-2] && !rst_h[c-1] && !rst_h[c];
      eu = (c >= 1) && miss_h[c-1] && !rst_h[c];
      if (ev) begin
        e_dout = dat_h[c-1][q_h[c-2]];
        e_dq   = q_h[c-2];
      end
      e_pop = hit_h[c] ? QQ'(1 << q_h[c]) : '0;
      chk("fifo_pop",       32'(fifo_pop),       32'(e_pop),          c);
      chk("buf_empty",      32'(buf_empty),      32'(fifo_empty),     c);
      chk("data_valid",     32'(data_valid),     32'(ev),             c);
      chk("data_out",       32'(data_out),       32'(e_dout),         c);
      chk("data_queue",     32'(data_queue),     32'(e_dq),           c);
      chk("underrun",       32'(underrun),       32'(eu),             c);
      chk("count_out",      32'(count_out),      32'(svc[count_sel]), c);
      chk("underrun_count", 32'(underrun_count), 32'(ucnt),           c);
      if (ev && svc[e_dq] < CMAX) svc[e_dq]++;
      if (eu && ucnt < CMAX)      ucnt++;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
